// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one external W-bit adder between N_REQ clients.
// Operands are registered on grant and the result is returned with the client id.
module adder_arbiter #(
    parameter int N_REQ = 4,
    parameter int W = 6,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_x,
    input  logic [N_REQ*W-1:0] req_y,
    output logic [W-1:0]       add_x,
    output logic [W-1:0]       add_y,
    input  logic [W-1:0]       add_s,
    input  logic               add_ov,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [W-1:0]       rsp_sum,
    output logic               rsp_ov,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] sel;
    logic [ID_W-1:0] idx;
    logic            found;
    logic [W-1:0]    op_x;
    logic [W-1:0]    op_y;

    // First requesting slot after the last grant, wrapping around.
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % N_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE && found) begin
            req_ready[sel] = 1'b1;
        end
    end

    assign add_x = op_x;
    assign add_y = op_y;
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= ID_W'(N_REQ - 1);
            op_x      <= '0;
            op_y      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_ov    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        op_x   <= req_x[int'(sel)*W +: W];
                        op_y   <= req_y[int'(sel)*W +: W];
                        rsp_id <= sel;
                        ptr    <= sel;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_sum   <= add_s;
                    rsp_ov    <= add_ov;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter with a behavioural adder and arbiter model.
module tb_adder_arbiter;
    localparam int N = 4;
    localparam int W = 6;
    localparam int IW = 2;

    typedef struct {
        int x;
        int y;
    } op_t;

    typedef struct {
        int id;
        int x;
        int y;
        int acc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_x = '0;
    logic [N*W-1:0] req_y = '0;
    logic [W-1:0]   add_x;
    logic [W-1:0]   add_y;
    logic [W-1:0]   add_s;
    logic           add_ov;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic [IW-1:0]  rsp_id;
    logic [W-1:0]   rsp_sum;
    logic           rsp_ov;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mptr = N - 1;
    int rmode = 0;
    bit drv_en = 0;
    bit gaps = 0;
    logic [N-1:0] acc_mask = '0;
    int cur_x [N];
    int cur_y [N];
    op_t opq [N][$];
    exp_t q [$];
    int glog [$];
    int last_id, last_sum, last_ov;

    adder_arbiter #(.N_REQ(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y),
        .add_x(add_x), .add_y(add_y),
        .add_s(add_s), .add_ov(add_ov),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_ov(rsp_ov),
        .busy(busy)
    );

    // External adder
    assign {add_ov, add_s} = add_x + add_y;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(string nm, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    // Requester and response-side drivers
    initial begin
        op_t o;
        forever begin
            @(posedge clk);
            #1;
            if (drv_en) begin
                for (int i = 0; i < N; i++) begin
                    if (acc_mask[i]) req_valid[i] = 1'b0;
                    if (!req_valid[i] && opq[i].size() > 0 &&
                        (!gaps || $urandom_range(0, 2) == 0)) begin
                        o = opq[i].pop_front();
                        cur_x[i] = o.x;
                        cur_y[i] = o.y;
                        req_x[i*W +: W] = W'(o.x);
                        req_y[i*W +: W] = W'(o.y);
                        req_valid[i] = 1'b1;
                    end
                end
            end
            if (rmode == 0) rsp_ready = 1'b1;
            else if (rmode == 1) rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: model arbitration and check the response channel
    always @(negedge clk) begin
        int pick;
        int j;
        int e_ready;
        bit idle_now;
        bit exp_v;
        acc_mask = '0;
        if (!rst_n) begin
            chk("rst_req_ready", int'(req_ready), 0);
            chk("rst_rsp_valid", int'(rsp_valid), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_add_x", int'(add_x), 0);
            chk("rst_add_y", int'(add_y), 0);
            q.delete();
            mptr = N - 1;
        end else begin
            idle_now = (q.size() == 0);
            pick = -1;
            e_ready = 0;
            if (idle_now) begin
                for (int k = 1; k <= N; k++) begin
                    j = (mptr + k) % N;
                    if (pick < 0 && req_valid[j]) pick = j;
                end
                if (pick >= 0) e_ready = 1 << pick;
            end
            chk("busy", int'(busy), idle_now ? 0 : 1);
            chk("req_ready", int'(req_ready), e_ready);
            exp_v = !idle_now && cyc >= q[0].acc + 1;
            chk("rsp_valid", int'(rsp_valid), int'(exp_v));
            if (!idle_now) begin
                chk("add_x", int'(add_x), q[0].x);
                chk("add_y", int'(add_y), q[0].y);
            end
            if (exp_v && rsp_valid) begin
                chk("rsp_id", int'(rsp_id), q[0].id);
                chk("rsp_sum", int'(rsp_sum), (q[0].x + q[0].y) % 64);
                chk("rsp_ov", int'(rsp_ov), (q[0].x + q[0].y) >= 64 ? 1 : 0);
                if (rsp_ready) begin
                    last_id = int'(rsp_id);
                    last_sum = int'(rsp_sum);
                    last_ov = int'(rsp_ov);
                    void'(q.pop_front());
                end
            end
            if (idle_now && pick >= 0) begin
                q.push_back('{id: pick, x: cur_x[pick], y: cur_y[pick], acc: cyc + 1});
                mptr = pick;
                acc_mask[pick] = 1'b1;
                glog.push_back(pick);
            end
        end
    end

    function automatic bit pending();
        bit p;
        p = (q.size() != 0) || (req_valid != '0);
        for (int i = 0; i < N; i++) if (opq[i].size() != 0) p = 1;
        return p;
    endfunction

    task automatic wait_idle(int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (pending() && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("timeout", int'(n < budget), 1);
    endtask

    task automatic push(int i, int x, int y);
        opq[i].push_back('{x: x, y: y});
    endtask

    task automatic chk_log(string nm, int exp_q[$]);
        chk({nm, "_len"}, glog.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < glog.size(); i++) begin
            chk(nm, glog[i], exp_q[i]);
        end
    endtask

    initial begin
        int n;
        #1 rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            req_valid = N'($urandom);
            req_x = N*W'($urandom);
            req_y = N*W'($urandom);
            rsp_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        rst_n = 1'b1;
        drv_en = 1;
        repeat (3) @(posedge clk);

        push(0, 25, 17);
        wait_idle(50);
        chk("t2_id", last_id, 0);
        chk("t2_sum", last_sum, 42);
        chk("t2_ov", last_ov, 0);

        push(2, 63, 1);
        wait_idle(50);
        chk("t3a_id", last_id, 2);
        chk("t3a_sum", last_sum, 0);
        chk("t3a_ov", last_ov, 1);
        push(2, 32, 32);
        wait_idle(50);
        chk("t3b_sum", last_sum, 0);
        chk("t3b_ov", last_ov, 1);

        push(3, 1, 2);
        wait_idle(50);
        @(negedge clk);
        glog.delete();
        push(0, 1, 1); push(0, 2, 2);
        push(1, 3, 3); push(2, 4, 4); push(3, 5, 5);
        wait_idle(100);
        chk_log("t4_all", '{0, 1, 2, 3, 0});

        @(negedge clk);
        glog.delete();
        push(1, 7, 8); push(1, 9, 10); push(3, 11, 12);
        wait_idle(100);
        chk_log("t4_odd", '{1, 3, 1});

        rmode = 2;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        push(1, 10, 20);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_wait", int'(n < 20), 1);
        push(3, 40, 50);
        repeat (5) @(negedge clk);
        chk("t5_hold_sum", int'(rsp_sum), 30);
        chk("t5_hold_ready", int'(req_ready), 0);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        rmode = 0;
        wait_idle(50);
        chk("t5_last_id", last_id, 3);

        @(negedge clk);
        glog.delete();
        push(1, 5, 6);
        n = 0;
        while (glog.size() == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6_acc", int'(n < 20), 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t6_no_rsp", int'(rsp_valid), 0);
        glog.delete();
        push(2, 1, 2); push(0, 3, 4);
        wait_idle(50);
        chk_log("t6_order", '{0, 2});

        rmode = 1;
        gaps = 1;
        for (int k = 0; k < 40; k++) begin
            push($urandom_range(0, N - 1), $urandom_range(0, 63), $urandom_range(0, 63));
        end
        wait_idle(3000);
        rmode = 0;
        gaps = 0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got 0 want 1");
        $fatal(1);
    end

endmodule
